// File: rtl/load_store_unit_if.sv
// Request/response handshake and word-memory bus for load_store_unit.
// The slave modport is the LSU; master is the core plus data memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word loads and stores onto a word-only memory; sub-word stores are read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of ignoring the low address bits.
module load_store_unit #(
    parameter int MEM_ADDR_BITS = 14
) (
    input  logic             clk,
    input  logic             resetn,
    load_store_unit_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  lat_lsb;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic        lat_we;
    logic [15:0] lat_wdata;

    logic        accept;
    logic        misaligned;
    logic        sub_word;
    logic [31:0] word_addr;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        unused_addr_bits;

    // req_ready is registered and only high in IDLE, so it doubles as the state qualifier
    assign accept           = bus.req_valid & bus.req_ready;
    assign sub_word         = (bus.req_size == 2'b00) | (bus.req_size == 2'b01);
    assign word_addr        = {{(32-MEM_ADDR_BITS){1'b0}}, bus.req_addr[MEM_ADDR_BITS-1:2], 2'b00};
    assign unused_addr_bits = ^bus.req_addr[31:MEM_ADDR_BITS];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((bus.req_size == 2'b01) & bus.req_addr[0]) |
                        (bus.req_size[1] & (bus.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Lane extraction for loads and lane replacement for read-modify-write, both from mem_rdata
    always_comb begin
        byte_val  = bus.mem_rdata[{lat_lsb, 3'b000} +: 8];
        half_val  = bus.mem_rdata[{lat_lsb[1], 4'b0000} +: 16];
        load_data = bus.mem_rdata;
        merged    = bus.mem_rdata;
        case (lat_size)
            2'b00: begin
                load_data = {{24{byte_val[7] & ~lat_unsigned}}, byte_val};
                merged[{lat_lsb, 3'b000} +: 8] = lat_wdata[7:0];
            end
            2'b01: begin
                load_data = {{16{half_val[15] & ~lat_unsigned}}, half_val};
                merged[{lat_lsb[1], 4'b0000} +: 16] = lat_wdata;
            end
            default: begin
                load_data = bus.mem_rdata;
                merged    = bus.mem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            lat_lsb       <= 2'b00;
            lat_size      <= 2'b00;
            lat_unsigned  <= 1'b0;
            lat_we        <= 1'b0;
            lat_wdata     <= 16'h0000;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.mem_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        lat_lsb       <= bus.req_addr[1:0];
                        lat_size      <= bus.req_size;
                        lat_unsigned  <= bus.req_unsigned;
                        lat_we        <= bus.req_we;
                        lat_wdata     <= bus.req_wdata[15:0];
                        bus.rsp_err   <= misaligned;
                        if (misaligned) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= 32'h0;
                        end else begin
                            bus.mem_addr <= word_addr;
                            // Full-word stores need no read, so they skip straight to the write
                            if (bus.req_we && !sub_word) begin
                                state         <= WRITE;
                                bus.mem_wdata <= bus.req_wdata;
                                bus.mem_we    <= 1'b1;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (lat_we) begin
                        state         <= WRITE;
                        bus.mem_wdata <= merged;
                        bus.mem_we    <= 1'b1;
                    end else begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= load_data;
                    end
                end
                WRITE: begin
                    state         <= RESP;
                    bus.mem_we    <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= 32'h0;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written corner
// sequences (backpressure, reset mid-RMW) and randomized traffic against a word-array model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic resetn;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_ADDR_BITS(14)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural word memory with a side port for preloading
    logic [31:0] mem_arr [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_idx = 12'h0;
    logic [31:0] pre_data = 32'h0;
    int          we_count = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    assign bus.mem_rdata = mem_arr[bus.mem_addr[13:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem_arr[bus.mem_addr[13:2]] <= bus.mem_wdata;
            we_count     <= we_count + 1;
            last_wr_addr <= bus.mem_addr;
            last_wr_data <= bus.mem_wdata;
        end else if (pre_we) begin
            mem_arr[pre_idx] <= pre_data;
        end
    end

    int checks = 0;
    int failures = 0;
    logic [31:0] ref_mem [int];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          pulses;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
    } result_t;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_pulses;
        logic [31:0] exp_wr_data;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: plain shift/mask arithmetic on a word
    function automatic logic model_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_extract(input logic [31:0] w, input logic [31:0] a,
                                                  input logic [1:0] sz, input logic uns);
        int unsigned v;
        int unsigned sh;
        case (sz)
            2'd0: begin
                sh = 8 * (a % 4);
                v  = (w >> sh) & 32'hFF;
                if (!uns && v >= 128) v = v - 32'd256;
            end
            2'd1: begin
                sh = 16 * ((a / 2) % 2);
                v  = (w >> sh) & 32'hFFFF;
                if (!uns && v >= 32768) v = v - 32'd65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] d);
        int unsigned sh;
        int unsigned mask;
        case (sz)
            2'd0: begin
                sh   = 8 * (a % 4);
                mask = 32'hFF << sh;
                return (w & ~mask) | ((d & 32'hFF) << sh);
            end
            2'd1: begin
                sh   = 16 * ((a / 2) % 2);
                mask = 32'hFFFF << sh;
                return (w & ~mask) | ((d & 32'hFFFF) << sh);
            end
            default: return d;
        endcase
    endfunction

    task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
        pre_idx  = byte_addr[13:2];
        pre_data = data;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
        ref_mem[int'(byte_addr[13:2])] = data;
    endtask

    // One full request/response transaction; holds rsp_ready low for 'hold' cycles once valid
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int hold, output result_t r);
        int guard;
        int w0;
        r = '{rdata: 32'h0, err: 1'b0, lat: 0, pulses: 0, wr_addr: 32'h0, wr_data: 32'h0};
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!bus.req_ready) begin
            checkOutput("req_ready_wait", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        w0 = we_count;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        r.lat = 1;
        while (!bus.rsp_valid && r.lat < 20) begin
            @(posedge clk);
            #1;
            r.lat++;
        end
        r.rdata = bus.rsp_rdata;
        r.err   = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("hold_rsp_rdata", bus.rsp_rdata, r.rdata);
            checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checkOutput("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("post_req_ready", 32'(bus.req_ready), 32'd1);
        r.pulses  = we_count - w0;
        r.wr_addr = last_wr_addr;
        r.wr_data = last_wr_data;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t    vecs[$];
        result_t r;
        int      w0;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b0;
        resetn           = 1'b1;
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err",   32'(bus.rsp_err), 32'd0);
        checkOutput("reset_mem_addr",  bus.mem_addr, 32'h0);
        checkOutput("reset_mem_wdata", bus.mem_wdata, 32'h0);
        checkOutput("reset_mem_we",    32'(bus.mem_we), 32'd0);
        resetn = 1'b1;

        preload(32'h10, 32'h0000_0000);
        preload(32'h14, 32'h0000_0000);
        preload(32'h20, 32'h1122_3344);
        preload(32'h30, 32'h80FF_7F01);
        preload(32'h40, 32'h5555_5555);

        // name, we, size, uns, addr, wdata, exp_rdata, exp_err, exp_lat, exp_pulses, exp_wr_data
        vecs.push_back('{"st_word_10",   1'b1, 2'd2, 1'b0, 32'h10,   32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1, 32'hDEAD_BEEF});
        vecs.push_back('{"ld_word_10",   1'b0, 2'd2, 1'b0, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{"st_byte_22",   1'b1, 2'd0, 1'b0, 32'h22,   32'hFFFF_FFAB, 32'h0,         1'b0, 3, 1, 32'h11AB_3344});
        vecs.push_back('{"ld_word_20",   1'b0, 2'd2, 1'b0, 32'h20,   32'h0,         32'h11AB_3344, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{"ld_sbyte_32",  1'b0, 2'd0, 1'b0, 32'h32,   32'h0,         32'hFFFF_FFFF, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{"ld_ubyte_32",  1'b0, 2'd0, 1'b1, 32'h32,   32'h0,         32'h0000_00FF, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{"ld_shalf_32",  1'b0, 2'd1, 1'b0, 32'h32,   32'h0,         32'hFFFF_80FF, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{"ld_uhalf_30",  1'b0, 2'd1, 1'b1, 32'h30,   32'h0,         32'h0000_7F01, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{"ld_sbyte_31",  1'b0, 2'd0, 1'b0, 32'h31,   32'h0,         32'h0000_007F, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{"st_half_22",   1'b1, 2'd1, 1'b0, 32'h22,   32'h1234_CAFE, 32'h0,         1'b0, 3, 1, 32'hCAFE_3344});
        vecs.push_back('{"ld_word_20b",  1'b0, 2'd2, 1'b1, 32'h20,   32'h0,         32'hCAFE_3344, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{"ld_wrap_4010", 1'b0, 2'd2, 1'b0, 32'h4010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{"st_rsvd_14",   1'b1, 2'd3, 1'b0, 32'h14,   32'h1234_5678, 32'h0,         1'b0, 2, 1, 32'h1234_5678});
        vecs.push_back('{"ld_rsvd_14",   1'b0, 2'd3, 1'b0, 32'h14,   32'h0,         32'h1234_5678, 1'b0, 2, 0, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{"ld_mis_13",    1'b0, 2'd2, 1'b0, 32'h13,   32'h0,         32'h0,         1'b1, 1, 0, 32'h0});
        vecs.push_back('{"st_mis_31",    1'b1, 2'd1, 1'b0, 32'h31,   32'hBEEF,      32'h0,         1'b1, 1, 0, 32'h0});
`else
        vecs.push_back('{"ld_mis_13",    1'b0, 2'd2, 1'b0, 32'h13,   32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0});
        vecs.push_back('{"ld_hmis_33",   1'b0, 2'd1, 1'b1, 32'h33,   32'h0,         32'h0000_80FF, 1'b0, 2, 0, 32'h0});
`endif

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].we, vecs[k].size, vecs[k].uns, vecs[k].addr, vecs[k].wdata, 0, r);
            checkOutput({vecs[k].name, "_rdata"}, r.rdata, vecs[k].exp_rdata);
            checkOutput({vecs[k].name, "_err"}, 32'(r.err), 32'(vecs[k].exp_err));
            checkOutput({vecs[k].name, "_latency"}, 32'(r.lat), 32'(vecs[k].exp_lat));
            checkOutput({vecs[k].name, "_we_pulses"}, 32'(r.pulses), 32'(vecs[k].exp_pulses));
            if (vecs[k].exp_pulses == 1) begin
                checkOutput({vecs[k].name, "_wr_addr"}, r.wr_addr, vecs[k].addr & 32'h3FFC);
                checkOutput({vecs[k].name, "_wr_data"}, r.wr_data, vecs[k].exp_wr_data);
            end
        end

        // Backpressure: rsp_ready held low for 5 cycles after a load
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 5, r);
        checkOutput("bp_rdata", r.rdata, 32'h80FF_7F01);
        checkOutput("bp_latency", 32'(r.lat), 32'd2);

        // Reset asserted while a byte store to 0x40 sits in READ
        w0 = we_count;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h41;
        bus.req_wdata    = 32'h77;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkOutput("rst_mid_busy", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_mid_addr_before", bus.mem_addr, 32'h40);
        #2 resetn = 1'b0;
        #1;
        checkOutput("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_mid_rsp_rdata", bus.rsp_rdata, 32'h0);
        checkOutput("rst_mid_rsp_err",   32'(bus.rsp_err), 32'd0);
        checkOutput("rst_mid_mem_addr",  bus.mem_addr, 32'h0);
        checkOutput("rst_mid_mem_wdata", bus.mem_wdata, 32'h0);
        checkOutput("rst_mid_mem_we",    32'(bus.mem_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        checkOutput("rst_mid_no_write", 32'(we_count - w0), 32'd0);
        checkOutput("rst_mid_mem_40", mem_arr[12'h010], 32'h5555_5555);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, r);
        checkOutput("rst_mid_load_40", r.rdata, 32'h5555_5555);

        // Randomized traffic over a 16-word window, sometimes with junk high address bits
        for (int i = 0; i < 16; i++) preload(32'h100 + 32'(i * 4), $urandom);
        for (int n = 0; n < 150; n++) begin
            logic        we;
            logic [1:0]  sz;
            logic        uns;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] exp_rdata;
            logic        mis;
            int          idx;
            int          exp_lat;
            int          exp_pulses;
            we  = 1'($urandom % 2);
            sz  = 2'($urandom % 4);
            uns = 1'($urandom % 2);
            a   = 32'h100 + ($urandom % 64);
            if ($urandom % 4 == 0) a = a | ($urandom << 14);
            d   = $urandom;
            idx = int'((a & 32'h3FFF) >> 2);
            mis = model_misaligned(sz, a);
            exp_rdata  = 32'h0;
            exp_pulses = 0;
            if (mis) begin
                exp_lat = 1;
            end else if (we) begin
                ref_mem[idx] = model_merge(ref_mem[idx], a, sz, d);
                exp_lat      = (sz < 2'd2) ? 3 : 2;
                exp_pulses   = 1;
            end else begin
                exp_rdata = model_extract(ref_mem[idx], a, sz, uns);
                exp_lat   = 2;
            end
            applyStimulus(we, sz, uns, a, d, int'($urandom % 3), r);
            checkOutput("rand_rdata", r.rdata, exp_rdata);
            checkOutput("rand_err", 32'(r.err), 32'(mis));
            checkOutput("rand_latency", 32'(r.lat), 32'(exp_lat));
            checkOutput("rand_we_pulses", 32'(r.pulses), 32'(exp_pulses));
        end
        for (int i = 0; i < 16; i++) begin
            checkOutput("rand_final_mem", mem_arr[12'h040 + 12'(i)], ref_mem[16'h40 + i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
